wca_lime_iq_deframer: RTL and testbench
=======================================

// Module: wca_lime_iq_deframer
// PURPOSE
//  Generalised receive deframer for Lime baseband port. Pairs interleaved I/Q ADC words
//  (iqsel-tagged) into one {Q,I} word per sample with a 1-cycle strobe. Adds a per-channel
//  leaky-integrator DC remover, test/ramp patterns, I/Q swap, sequence-error flag, pair counter.
//  Sits between the pad-side rx capture and the DSP chain, all in the clock_dsp domain.
// PARAMETERS
//  DW        12  sample width per channel, signed two's complement (min 8)
//  DC_SHIFT  10  DC integrator time constant, 2^DC_SHIFT pairs (1..16)
//  CNT_W     16  width of pair_count
// PORTS
//  clock       in   1        DSP clock, all logic on rising edge
//  reset_n     in   1        asynchronous active-low reset
//  enable      in   1        1 = deframe; 0 = idle (see behaviour)
//  mode        in   2        0 raw, 1 DC-removed, 2 fixed pattern, 3 ramp
//  iq_swap     in   1        1 = exchange I and Q halves at output
//  in_valid    in   1        in_data/in_iqsel valid this cycle
//  in_iqsel    in   1        1 = I word, 0 = Q word
//  in_data     in   DW       ADC word, signed
//  err_clr     in   1        clears err_seq
//  out_iq      out  2*DW     {Q[2DW-1:DW], I[DW-1:0]}
//  out_strobe  out  1        one-cycle pulse, out_iq new this cycle
//  dc_i        out  DW       current I DC estimate
//  dc_q        out  DW       current Q DC estimate
//  err_seq     out  1        sticky I/Q sequence error
//  pair_count  out  CNT_W    pairs emitted since reset, wraps
// BEHAVIOUR
//  - Reset (reset_n=0, async): all outputs, FSM, latches, accumulators = 0; FSM = WAIT_I.
//  - FSM WAIT_I / WAIT_Q, advances only on in_valid=1 with enable=1:
//    WAIT_I, iqsel=1: latch I, -> WAIT_Q.  WAIT_I, iqsel=0: discard, set err_seq, stay.
//    WAIT_Q, iqsel=0: latch Q, form pair, -> WAIT_I.
//    WAIT_Q, iqsel=1: overwrite latched I, set err_seq, stay WAIT_Q.
//  - Latency: Q accepted on edge N -> out_iq valid, out_strobe=1 for the cycle after edge N+1.
//    out_iq holds between strobes; out_strobe never high two consecutive cycles.
//  - Mode sampled when pair is formed; mid-pair mode change affects only that pair's output.
//    0: I,Q as latched.
//    1: x - dc, dc = pre-update estimate; result saturated to [-2^(DW-1), 2^(DW-1)-1].
//    2: I = +2^(DW-4), Q = -2^(DW-4) (DW=12: 12'h100 / 12'hF00).
//    3: I = pair_count[DW-1:0] (pre-increment), Q = ~I.
//    Modes 2/3 still need paired input for strobe timing.
//  - DC: per channel signed acc, DW+DC_SHIFT bits; on each formed pair (all modes):
//    acc <= acc + x - (acc >>> DC_SHIFT); dc = acc >>> DC_SHIFT (arith shift, truncated).
//    No acc overflow possible by construction; acc never saturates.
//  - iq_swap applied after mode mux.
//  - pair_count increments with each strobe; wraps 2^CNT_W-1 -> 0 silently.
//  - err_clr clears err_seq; error event and err_clr in same cycle -> err_seq = 1.
//  - enable=0: FSM forced to WAIT_I (partial pair dropped), no strobe, acc/dc/count/out_iq held;
//    a strobe already pending from the previous cycle still issues.
//  - reset_n asserted mid-pair: no strobe for the partial pair after release.
// TESTING
//  1 Reset: reset_n=0 mid-stream -> all outputs 0 immediately; after release first pair needs I then Q.
//  2 Raw: mode=0, I=12'h123,Q=12'hABC -> out_iq=24'hABC123, one strobe 2 cycles after Q; swap=1 -> 24'h123ABC.
//  3 DC: mode=1, DC_SHIFT=4, constant I=100,Q=-50 for 400 pairs -> dc_i=99..100, dc_q=-50..-49, out within +/-1 of 0.
//  4 Saturation: mode=1, preload dc_i=+1000 via 400 pairs of I=1000, then I=-2048 -> out I = -2048 (clamped).
//  5 Sequence: I,I,Q -> err_seq=1, pair uses second I; Q in WAIT_I discarded; err_clr+new error same cycle -> stays 1.
//  6 Patterns/wrap: mode=2 -> 24'hF00100; mode=3, CNT_W=4, 20 pairs -> count wraps 15->0, I tracks count, Q=~I.

Source files
------------

// File: rtl/wca_lime_iq_deframer.sv
// rtl/wca_lime_iq_deframer.sv - Lime rx I/Q deframer with DC remover, test patterns and pair counter
module wca_lime_iq_deframer #(
    parameter int DW       = 12,
    parameter int DC_SHIFT = 10,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                iq_swap,
    input  logic                in_valid,
    input  logic                in_iqsel,
    input  logic [DW-1:0]       in_data,
    input  logic                err_clr,
    output logic [2*DW-1:0]     out_iq,
    output logic                out_strobe,
    output logic [DW-1:0]       dc_i,
    output logic [DW-1:0]       dc_q,
    output logic                err_seq,
    output logic [CNT_W-1:0]    pair_count
);

    localparam int AW = DW + DC_SHIFT;
    localparam logic [DW-1:0] ONE   = DW'(1);
    localparam logic [DW-1:0] PAT_P = ONE << (DW - 4);
    localparam logic [DW-1:0] PAT_N = ~PAT_P + ONE;

    typedef enum logic {
        WAIT_I = 1'b0,
        WAIT_Q = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic take_i;
    logic take_q;
    logic seq_err;

    logic [DW-1:0] lat_i;
    logic [DW-1:0] lat_q;
    logic [1:0]    lat_mode;
    logic          lat_swap;
    logic          pend;

    logic [AW-1:0] acc_i;
    logic [AW-1:0] acc_q;

    logic [DW-1:0] cnt_lo;
    logic [DW-1:0] res_i;
    logic [DW-1:0] res_q;

    // x - dc, clamped to the signed DW-bit range
    function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] x, input logic [DW-1:0] dc);
        logic [DW:0] d;
        d = {x[DW-1], x} - {dc[DW-1], dc};
        if (d[DW] != d[DW-1])
            return d[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return d[DW-1:0];
    endfunction

    // Leaky integrator; steady-state |acc| <= 2^(AW-1), so AW bits never wrap
    function automatic logic [AW-1:0] acc_next(input logic [AW-1:0] acc, input logic [DW-1:0] x);
        logic [AW-1:0] sh;
        sh = $signed(acc) >>> DC_SHIFT;
        return acc + {{DC_SHIFT{x[DW-1]}}, x} - sh;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= WAIT_I;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable)
            state_nxt = WAIT_I;
        else if (in_valid) begin
            if (state == WAIT_I)
                state_nxt = in_iqsel ? WAIT_Q : WAIT_I;
            else
                state_nxt = in_iqsel ? WAIT_Q : WAIT_I;
        end
    end

    // An I word is always latched: in WAIT_Q it replaces the stale I
    always_comb begin
        take_i  = 1'b0;
        take_q  = 1'b0;
        seq_err = 1'b0;
        if (enable && in_valid) begin
            take_i = in_iqsel;
            if (state == WAIT_I) begin
                seq_err = !in_iqsel;
            end else begin
                take_q  = !in_iqsel;
                seq_err = in_iqsel;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_i    <= '0;
            lat_q    <= '0;
            lat_mode <= 2'd0;
            lat_swap <= 1'b0;
            pend     <= 1'b0;
            err_seq  <= 1'b0;
        end else begin
            if (take_i)
                lat_i <= in_data;
            if (take_q) begin
                lat_q    <= in_data;
                lat_mode <= mode;
                lat_swap <= iq_swap;
            end
            pend    <= take_q;
            err_seq <= seq_err | (err_seq & ~err_clr);
        end
    end

    assign dc_i = DW'($signed(acc_i) >>> DC_SHIFT);
    assign dc_q = DW'($signed(acc_q) >>> DC_SHIFT);

    generate
        if (CNT_W >= DW) begin : g_cnt_trunc
            assign cnt_lo = pair_count[DW-1:0];
        end else begin : g_cnt_ext
            assign cnt_lo = {{(DW-CNT_W){1'b0}}, pair_count};
        end
    endgenerate

    always_comb begin
        res_i = lat_i;
        res_q = lat_q;
        case (lat_mode)
            2'd1: begin
                res_i = sat_sub(lat_i, dc_i);
                res_q = sat_sub(lat_q, dc_q);
            end
            2'd2: begin
                res_i = PAT_P;
                res_q = PAT_N;
            end
            2'd3: begin
                res_i = cnt_lo;
                res_q = ~cnt_lo;
            end
            default: begin
                res_i = lat_i;
                res_q = lat_q;
            end
        endcase
    end

    // Output stage runs on the pending flag only, so a pair formed just before enable drops still issues
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_iq     <= '0;
            out_strobe <= 1'b0;
            acc_i      <= '0;
            acc_q      <= '0;
            pair_count <= '0;
        end else begin
            out_strobe <= pend;
            if (pend) begin
                out_iq     <= lat_swap ? {res_i, res_q} : {res_q, res_i};
                acc_i      <= acc_next(acc_i, lat_i);
                acc_q      <= acc_next(acc_q, lat_q);
                pair_count <= pair_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wca_lime_iq_deframer.sv
// tb/tb_wca_lime_iq_deframer.sv - scoreboard bench for wca_lime_iq_deframer
module tb_wca_lime_iq_deframer;

    localparam int DW = 12;
    localparam int S  = 4;
    localparam int CW = 4;

    logic          clock;
    logic          reset_n;
    logic          enable;
    logic [1:0]    mode;
    logic          iq_swap;
    logic          in_valid;
    logic          in_iqsel;
    logic [DW-1:0] in_data;
    logic          err_clr;
    logic [2*DW-1:0] out_iq;
    logic          out_strobe;
    logic [DW-1:0] dc_i;
    logic [DW-1:0] dc_q;
    logic          err_seq;
    logic [CW-1:0] pair_count;

    wca_lime_iq_deframer #(.DW(DW), .DC_SHIFT(S), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .iq_swap    (iq_swap),
        .in_valid   (in_valid),
        .in_iqsel   (in_iqsel),
        .in_data    (in_data),
        .err_clr    (err_clr),
        .out_iq     (out_iq),
        .out_strobe (out_strobe),
        .dc_i       (dc_i),
        .dc_q       (dc_q),
        .err_seq    (err_seq),
        .pair_count (pair_count)
    );

    typedef struct {
        logic [2*DW-1:0] iq;
        logic [DW-1:0]   dci;
        logic [DW-1:0]   dcq;
        logic [CW-1:0]   cnt;
        int              cyc;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;

    bit            m_have_i;
    logic [DW-1:0] m_i;
    bit            m_err;
    int            m_acc_i;
    int            m_acc_q;
    int            m_cnt;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic model_clear();
        m_have_i = 0;
        m_i      = '0;
        m_err    = 0;
        m_acc_i  = 0;
        m_acc_q  = 0;
        m_cnt    = 0;
        sb.delete();
    endtask

    task automatic form_pair(input logic [DW-1:0] q);
        int xi, xq, di, dq, oi, oq;
        logic [DW-1:0] bi, bq;
        exp_t e;
        xi = $signed(m_i);
        xq = $signed(q);
        di = m_acc_i >>> S;
        dq = m_acc_q >>> S;
        case (mode)
            2'd0: begin oi = xi; oq = xq; end
            2'd1: begin oi = sat(xi - di); oq = sat(xq - dq); end
            2'd2: begin oi = 256; oq = -256; end
            default: begin oi = m_cnt; oq = -m_cnt - 1; end
        endcase
        bi = 12'(oi);
        bq = 12'(oq);
        m_acc_i = m_acc_i + xi - di;
        m_acc_q = m_acc_q + xq - dq;
        m_cnt   = (m_cnt + 1) % (1 << CW);
        e.iq  = iq_swap ? {bi, bq} : {bq, bi};
        e.dci = 12'(m_acc_i >>> S);
        e.dcq = 12'(m_acc_q >>> S);
        e.cnt = 4'(m_cnt);
        e.cyc = cyc_cnt;
        sb.push_back(e);
    endtask

    task automatic model_edge(input bit v, input bit sel, input logic [DW-1:0] d, input bit clr);
        bit evt;
        evt = 0;
        if (!enable)
            m_have_i = 0;
        else if (v) begin
            if (!m_have_i) begin
                if (sel) begin m_i = d; m_have_i = 1; end
                else evt = 1;
            end else if (sel) begin
                m_i = d;
                evt = 1;
            end else begin
                form_pair(d);
                m_have_i = 0;
            end
        end
        m_err = evt || (m_err && !clr);
    endtask

    task automatic step(input bit v, input bit sel, input logic [DW-1:0] d, input bit clr);
        in_valid = v;
        in_iqsel = sel;
        in_data  = d;
        err_clr  = clr;
        @(posedge clock);
        #1;
        model_edge(v, sel, d, clr);
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, '0, 0);
    endtask

    task automatic pair(input logic [DW-1:0] i, input logic [DW-1:0] q);
        step(1, 1, i, 0);
        step(1, 0, q, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_out_iq", out_iq, 0);
        chk("rst_strobe", out_strobe, 0);
        chk("rst_count", pair_count, 0);
        chk("rst_err", err_seq, 0);
        chk("rst_dc", {dc_q, dc_i}, 0);
        model_clear();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        bit last_str;
        last_str = 0;
        forever begin
            @(negedge clock);
            if (!reset_n)
                last_str = 0;
            else begin
                if (out_strobe) begin
                    chk("strobe_gap", last_str, 0);
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_strobe: out_iq=%0h, no pair expected", out_iq);
                    end else begin
                        e = sb.pop_front();
                        chk("out_iq", out_iq, e.iq);
                        chk("dc_i", dc_i, e.dci);
                        chk("dc_q", dc_q, e.dcq);
                        chk("pair_count", pair_count, e.cnt);
                        chk("latency", cyc_cnt, e.cyc + 1);
                    end
                end
                last_str = out_strobe;
            end
        end
    end

    initial begin
        bit sel;
        reset_n  = 1'b0;
        enable   = 1'b1;
        mode     = 2'd0;
        iq_swap  = 1'b0;
        in_valid = 1'b0;
        in_iqsel = 1'b0;
        in_data  = '0;
        err_clr  = 1'b0;
        model_clear();
        #12;
        do_reset();

        // raw and swap
        pair(12'h123, 12'hABC);
        idle(2);
        chk("raw", out_iq, 24'hABC123);
        iq_swap = 1'b1;
        pair(12'h123, 12'hABC);
        idle(2);
        chk("swap", out_iq, 24'h123ABC);
        iq_swap = 1'b0;

        // DC convergence
        do_reset();
        mode = 2'd1;
        repeat (400) pair(12'd100, 12'hFCE);
        idle(2);
        chk_rng("dc_i_conv", $signed(dc_i), 99, 100);
        chk_rng("dc_q_conv", $signed(dc_q), -50, -49);
        chk_rng("dcrm_i", $signed(out_iq[11:0]), -1, 1);
        chk_rng("dcrm_q", $signed(out_iq[23:12]), -1, 1);

        // saturation
        do_reset();
        repeat (400) pair(12'd1000, 12'd0);
        idle(2);
        chk_rng("dc_i_1000", $signed(dc_i), 999, 1000);
        pair(12'h800, 12'd0);
        idle(2);
        chk("sat_low", out_iq[11:0], 12'h800);

        // sequence errors
        mode = 2'd0;
        step(1, 1, 12'h111, 0);
        step(1, 1, 12'h222, 0);
        step(1, 0, 12'h333, 0);
        idle(2);
        chk("err_ii", err_seq, 1);
        chk("second_i", out_iq, 24'h333222);
        step(0, 0, '0, 1);
        chk("err_clr", err_seq, 0);
        step(1, 0, 12'h444, 1);
        chk("err_clr_vs_evt", err_seq, 1);
        idle(2);

        // patterns and count wrap
        mode = 2'd2;
        pair(12'h0AA, 12'h055);
        idle(2);
        chk("pattern", out_iq, 24'hF00100);
        mode = 2'd3;
        repeat (20) pair(12'($urandom), 12'($urandom));
        idle(2);

        // reset kills a partial pair
        mode = 2'd0;
        pair(12'h5A5, 12'h3C3);
        step(1, 0, 12'h001, 0);
        do_reset();
        step(1, 1, 12'h7FF, 0);
        do_reset();
        step(1, 0, 12'h321, 0);
        idle(2);
        chk("no_partial", pair_count, 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 31) == 0) iq_swap = 1'($urandom);
            sel = m_have_i ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
            step(($urandom_range(0, 9) < 7), sel, 12'($urandom), ($urandom_range(0, 19) == 0));
            chk("err_seq", err_seq, m_err);
        end
        enable = 1'b1;
        idle(4);
        chk("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
